// File: rtl/serial_input_deserializer.sv
// Collects DATA_W serial bits (MSB first, frame-qualified) into a sample, then commits it
// through a 3-stage write/flag/advance pipeline into a circular buffer address space.
module serial_input_deserializer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              Sclk,
   input  logic              Reset,
   input  logic              enable,
   input  logic              bit_en,
   input  logic              frame,
   input  logic              din,
   output logic [DATA_W-1:0] in_data,
   output logic              write_enable,
   output logic [ADDR_W-1:0] datawrite,
   output logic              in_flag,
   output logic [15:0]       word_cnt,
   output logic              framing_err
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [DATA_W-1:0]   shift_q;
   logic [DATA_W-1:0]   shift_d;
   logic [DATA_W-1:0]   msb_d;
   logic                last_bit;
   logic                done_q;
   logic                we_q;
   logic                flag_q;
   logic                ferr_q;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [15:0]         cnt_q;

   assign shift_d  = {shift_q[DATA_W-2:0], din};
   assign msb_d    = {{(DATA_W-1){1'b0}}, din};
   assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));

   always_ff @(posedge Sclk) begin
      if (Reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         flag_q    <= 1'b0;
         ferr_q    <= 1'b0;
         data_q    <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
         if (!enable) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
         end else if (bit_en) begin
            case (state_q)
               IDLE: begin
                  if (frame) begin
                     shift_q   <= msb_d;
                     bit_cnt_q <= CNT_W'(1);
                     state_q   <= SHIFT;
                  end
               end
               SHIFT: begin
                  // A frame mid-word restarts assembly with this bit as the new MSB
                  if (frame) begin
                     ferr_q    <= 1'b1;
                     shift_q   <= msb_d;
                     bit_cnt_q <= CNT_W'(1);
                  end else begin
                     shift_q <= shift_d;
                     if (last_bit) begin
                        done_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
               end
            endcase
         end

         // Commit runs independently so a new frame can shift in underneath it
         we_q   <= done_q;
         flag_q <= we_q;
         if (done_q) data_q <= shift_q;
         if (flag_q) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q + 16'd1;
         end
      end
   end

   assign in_data      = data_q;
   assign write_enable = we_q;
   assign datawrite    = addr_q;
   assign in_flag      = flag_q;
   assign word_cnt     = cnt_q;
   assign framing_err  = ferr_q;

endmodule
